// File: rtl/btn_debounce.sv
// btn_debounce: four-channel push-button conditioner.
// Each raw button is synchronised into clk through two flops. It is then
// debounced by a per-channel stability counter. The outputs are clean levels
// plus optional one-cycle press/release pulses.
// Optional feature macro: BTN_DEBOUNCE_EDGE_EN. When it is defined, the
// btn_rise/btn_fall pulse registers are built. Otherwise both ports are tied to 0.
module btn_debounce #(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CW              = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    output logic [N-1:0] btn_db,
    output logic [N-1:0] btn_rise,
    output logic [N-1:0] btn_fall
);

    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  db_q;
    logic [CW-1:0] cnt [N];
    logic [N-1:0]  upd;

    // Two-flop synchroniser for the asynchronous raw inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // A channel commits its pending change when the count has completed
    always_comb begin
        upd = '0;
        for (int unsigned i = 0; i < N; i++) begin
            upd[i] = (sync2[i] != db_q[i]) && (cnt[i] == LAST);
        end
    end

    // Per-channel stability counters and debounced levels
    always_ff @(posedge clk) begin
        if (rst) begin
            db_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sync2[i] == db_q[i]) begin
                    cnt[i] <= '0;
                end else if (upd[i]) begin
                    db_q[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_db = db_q;

`ifdef BTN_DEBOUNCE_EDGE_EN
    logic [N-1:0] rise_q;
    logic [N-1:0] fall_q;

    // Pulses register in the same edge as the level change, so each pulse
    // lines up with the first cycle of the new btn_db value
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= upd & sync2;
            fall_q <= upd & ~sync2;
        end
    end

    assign btn_rise = rise_q;
    assign btn_fall = fall_q;
`else
    assign btn_rise = '0;
    assign btn_fall = '0;
`endif

endmodule
